// File: rtl/sonic_ring_pkg.sv
// -----------------------------------------------------------------------------
// sonic_ring_pkg
// Shared constants, width helpers and the write-state enum for the RX page
// ring. Page geometry defaults describe a 4 KB page of 128-bit DMA words:
// 8 header words followed by 248 payload words (two 64-bit payloads per word).
// -----------------------------------------------------------------------------
package sonic_ring_pkg;

  localparam int BLOCK_W      = 66;   // one blocksync block: 2-bit header + 64-bit payload
  localparam int DMA_W        = 128;  // DMA word width
  localparam int HDR_PER_WORD = 64;   // 2-bit headers per DMA word
  localparam int HDR_SH       = $clog2(HDR_PER_WORD);

  localparam int DEF_NUM_PAGES       = 32;
  localparam int DEF_PAGE_WORDS      = 256;
  localparam int DEF_SYNC_WORDS      = 8;
  localparam int DEF_BLOCKS_PER_PAGE = 496;
  localparam int DEF_CNT_W           = 16;

  typedef enum logic [1:0] {
    IDLE_PAGE = 2'd0,  // at block 0, page accept/drop decision pending
    FILL      = 2'd1,  // page accepted, blocks are written
    DROP      = 2'd2   // page rejected, blocks are counted but discarded
  } wr_state_e;

  // Word address width across the whole ring.
  function automatic int addr_w(input int num_pages, input int page_words);
    return $clog2(num_pages * page_words);
  endfunction

  // Width of a count that must be able to hold num_pages itself.
  function automatic int pages_cnt_w(input int num_pages);
    return $clog2(num_pages) + 1;
  endfunction

endpackage

// File: rtl/sonic_ring_pack_66.sv
// -----------------------------------------------------------------------------
// sonic_ring_pack_66
// Block-index counter plus header and payload accumulators. Each accepted block
// advances k; headers collect into a 128-bit word flushed every 64 blocks (and
// at the last block of the page), payloads pair up into 128-bit words. Write
// requests for both RAMs are registered, so they hit the RAMs one cycle after
// the block that completed the word.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   block_i, valid_i   incoming 66-bit block and its qualifier
//   keep_i             this block belongs to an accepted page (write it)
//   page_i             current write page
//   last_o             combinational: valid block at k == BLOCKS_PER_PAGE-1
//   sync_*_o           header RAM write port (registered)
//   dat_*_o            payload RAM write port (registered)
// -----------------------------------------------------------------------------
module sonic_ring_pack_66
  import sonic_ring_pkg::*;
#(
  parameter int NUM_PAGES       = DEF_NUM_PAGES,
  parameter int PAGE_WORDS      = DEF_PAGE_WORDS,
  parameter int SYNC_WORDS      = DEF_SYNC_WORDS,
  parameter int BLOCKS_PER_PAGE = DEF_BLOCKS_PER_PAGE,
  localparam int PG_W = $clog2(NUM_PAGES),
  localparam int WD_W = $clog2(PAGE_WORDS),
  localparam int SW_W = $clog2(SYNC_WORDS),
  localparam int K_W  = $clog2(BLOCKS_PER_PAGE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [BLOCK_W-1:0]   block_i,
  input  logic                 valid_i,
  input  logic                 keep_i,
  input  logic [PG_W-1:0]      page_i,
  output logic                 last_o,
  output logic                 sync_we_o,
  output logic [PG_W+SW_W-1:0] sync_addr_o,
  output logic [DMA_W-1:0]     sync_wdata_o,
  output logic                 dat_we_o,
  output logic [PG_W+WD_W-1:0] dat_addr_o,
  output logic [DMA_W-1:0]     dat_wdata_o
);

  logic [K_W-1:0]   k_q;
  logic [DMA_W-1:0] hdr_q, hdr_d;
  logic [63:0]      pay_lo_q;
  logic             last_blk, hdr_done;

  // NOTE: every signal written here gets a value before any conditional
  // logic, so always_comb never infers a latch.
  always_comb begin
    last_blk = (k_q == K_W'(BLOCKS_PER_PAGE - 1));
    hdr_done = (k_q[HDR_SH-1:0] == '1) || last_blk;
    hdr_d    = hdr_q;
    hdr_d[{k_q[HDR_SH-1:0], 1'b0} +: 2] = block_i[1:0];
  end

  assign last_o = valid_i && last_blk;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      k_q          <= '0;
      hdr_q        <= '0;
      pay_lo_q     <= '0;
      sync_we_o    <= 1'b0;
      sync_addr_o  <= '0;
      sync_wdata_o <= '0;
      dat_we_o     <= 1'b0;
      dat_addr_o   <= '0;
      dat_wdata_o  <= '0;
    end else begin
      sync_we_o <= 1'b0;
      dat_we_o  <= 1'b0;
      if (valid_i) begin
        k_q <= last_blk ? '0 : k_q + K_W'(1);
        // Clearing after each flush leaves the unused tail of the last header
        // word at zero.
        hdr_q <= hdr_done ? '0 : hdr_d;
        if (!k_q[0]) pay_lo_q <= block_i[65:2];
        sync_we_o    <= keep_i && hdr_done;
        sync_addr_o  <= {page_i, SW_W'(k_q >> HDR_SH)};
        sync_wdata_o <= hdr_d;
        dat_we_o     <= keep_i && k_q[0];
        dat_addr_o   <= {page_i, WD_W'(SYNC_WORDS) + WD_W'(k_q >> 1)};
        dat_wdata_o  <= {block_i[65:2], pay_lo_q};
      end
    end
  end

endmodule

// File: rtl/sonic_rx_page_ring.sv
// -----------------------------------------------------------------------------
// sonic_rx_page_ring
// Page-granular RX ring for 66-bit blocks. Blocks are packed into 4 KB pages of
// 128-bit words (header words first, then payload words). A page is accepted
// or dropped as a whole at its first block; the DMA engine reads by address
// and releases pages in order with rd_page_done.
//
// Ports:
//   clk_in, reset_n     clock, synchronous active-low reset
//   data_in, data_valid 66-bit block ([1:0] header, [65:2] payload) + valid
//   rd_address          ring word address {page, word-in-page}
//   rd_data             read data, 2-cycle latency
//   rd_page_done        release pulse for the oldest ready page
//   pages_ready         complete, unreleased pages
//   ring_full           pages_ready == NUM_PAGES
//   overflow            sticky: a page was dropped
//   underflow           sticky: release seen with nothing ready
//   dropped_pages       saturating dropped-page count
// -----------------------------------------------------------------------------
module sonic_rx_page_ring
  import sonic_ring_pkg::*;
#(
  parameter int NUM_PAGES       = DEF_NUM_PAGES,
  parameter int PAGE_WORDS      = DEF_PAGE_WORDS,
  parameter int SYNC_WORDS      = DEF_SYNC_WORDS,
  parameter int BLOCKS_PER_PAGE = DEF_BLOCKS_PER_PAGE,
  parameter int CNT_W           = DEF_CNT_W,
  localparam int AW   = addr_w(NUM_PAGES, PAGE_WORDS),
  localparam int PR_W = pages_cnt_w(NUM_PAGES)
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_valid,
  input  logic [AW-1:0]      rd_address,
  output logic [DMA_W-1:0]   rd_data,
  input  logic               rd_page_done,
  output logic [PR_W-1:0]    pages_ready,
  output logic               ring_full,
  output logic               overflow,
  output logic               underflow,
  output logic [CNT_W-1:0]   dropped_pages
);

  localparam int PG_W = $clog2(NUM_PAGES);
  localparam int WD_W = AW - PG_W;
  localparam int SW_W = $clog2(SYNC_WORDS);

  wr_state_e         state_q;
  logic [PG_W-1:0]   wr_page_q;
  logic              commit_q, drop_q;
  logic [PR_W-1:0]   pages_ready_q, pages_ready_d, pages_eff;
  logic              ring_full_q, overflow_q, underflow_q;
  logic [CNT_W-1:0]  dropped_q;
  logic              accept, keep, last_blk;

  logic                 sync_we, dat_we;
  logic [PG_W+SW_W-1:0] sync_waddr;
  logic [AW-1:0]        dat_waddr;
  logic [DMA_W-1:0]     sync_wdata, dat_wdata;

  sonic_ring_pack_66 #(
    .NUM_PAGES      (NUM_PAGES),
    .PAGE_WORDS     (PAGE_WORDS),
    .SYNC_WORDS     (SYNC_WORDS),
    .BLOCKS_PER_PAGE(BLOCKS_PER_PAGE)
  ) u_pack (
    .clk_i       (clk_in),
    .rst_ni      (reset_n),
    .block_i     (data_in),
    .valid_i     (data_valid),
    .keep_i      (keep),
    .page_i      (wr_page_q),
    .last_o      (last_blk),
    .sync_we_o   (sync_we),
    .sync_addr_o (sync_waddr),
    .sync_wdata_o(sync_wdata),
    .dat_we_o    (dat_we),
    .dat_addr_o  (dat_waddr),
    .dat_wdata_o (dat_wdata)
  );

  always_comb begin
    // A page committed last cycle is not yet in pages_ready_q but already
    // occupies its slot, so the accept decision has to count it.
    pages_eff = pages_ready_q + PR_W'(commit_q);
    accept    = (pages_eff < PR_W'(NUM_PAGES)) || rd_page_done;
    keep      = (state_q == FILL) || ((state_q == IDLE_PAGE) && accept);
    pages_ready_d = pages_ready_q;
    if (commit_q && !rd_page_done) begin
      pages_ready_d = pages_ready_q + PR_W'(1);
    end else if (!commit_q && rd_page_done && (pages_ready_q != '0)) begin
      pages_ready_d = pages_ready_q - PR_W'(1);
    end
  end

  // Write FSM and page accounting. commit_q/drop_q delay the bookkeeping by one
  // cycle so the final word is in RAM before the page is counted.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q       <= IDLE_PAGE;
      wr_page_q     <= '0;
      commit_q      <= 1'b0;
      drop_q        <= 1'b0;
      pages_ready_q <= '0;
      ring_full_q   <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      dropped_q     <= '0;
    end else begin
      commit_q <= 1'b0;
      drop_q   <= 1'b0;
      if (data_valid) begin
        unique case (state_q)
          IDLE_PAGE: state_q <= accept ? FILL : DROP;
          FILL: if (last_blk) begin
            state_q   <= IDLE_PAGE;
            wr_page_q <= wr_page_q + PG_W'(1);
            commit_q  <= 1'b1;
          end
          DROP: if (last_blk) begin
            state_q <= IDLE_PAGE;
            drop_q  <= 1'b1;
          end
          default: state_q <= IDLE_PAGE;
        endcase
      end
      pages_ready_q <= pages_ready_d;
      ring_full_q   <= (pages_ready_d == PR_W'(NUM_PAGES));
      if (rd_page_done && !commit_q && (pages_ready_q == '0)) underflow_q <= 1'b1;
      if (drop_q) begin
        overflow_q <= 1'b1;
        if (dropped_q != '1) dropped_q <= dropped_q + CNT_W'(1);
      end
    end
  end

  assign pages_ready   = pages_ready_q;
  assign ring_full     = ring_full_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign dropped_pages = dropped_q;

  // Simple dual-port RAMs: header words and payload words.
  logic [DMA_W-1:0] sync_mem [NUM_PAGES*SYNC_WORDS];
  logic [DMA_W-1:0] dat_mem  [NUM_PAGES*PAGE_WORDS];

  // NOTE: the RAM arrays have no reset; clearing them would prevent RAM
  // inference, and page contents are only meaningful once committed.
  always_ff @(posedge clk_in) begin
    if (sync_we) sync_mem[sync_waddr] <= sync_wdata;
    if (dat_we)  dat_mem[dat_waddr]   <= dat_wdata;
  end

  // Read pipeline: registered address, registered RAM output, and the RAM
  // select delayed two stages to line up with the data.
  logic [AW-1:0]    rd_addr_q;
  logic [1:0]       sel_sync_q;
  logic [DMA_W-1:0] sync_rd_q, dat_rd_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      rd_addr_q  <= '0;
      sel_sync_q <= '0;
      sync_rd_q  <= '0;
      dat_rd_q   <= '0;
    end else begin
      rd_addr_q  <= rd_address;
      sel_sync_q <= {sel_sync_q[0], rd_address[WD_W-1:0] < WD_W'(SYNC_WORDS)};
      sync_rd_q  <= sync_mem[{rd_addr_q[AW-1:WD_W], rd_addr_q[SW_W-1:0]}];
      dat_rd_q   <= dat_mem[rd_addr_q];
    end
  end

  assign rd_data = sel_sync_q[1] ? sync_rd_q : dat_rd_q;

endmodule

// File: tb/tb_sonic_rx_page_ring.sv
// -----------------------------------------------------------------------------
// tb_sonic_rx_page_ring
// Self-checking bench for sonic_rx_page_ring. A page-level reference model
// (flat word array, ready/drop counters) is updated per block from the
// placement and accounting rules; DUT outputs are compared against it and
// against directed constants.
// -----------------------------------------------------------------------------
module tb_sonic_rx_page_ring;

  localparam int NUM_PAGES  = 32;
  localparam int PAGE_WORDS = 256;
  localparam int SYNC_WORDS = 8;
  localparam int BPP        = 496;
  localparam int CNT_W      = 16;
  localparam int AW         = 13;
  localparam int PR_W       = 6;

  logic             clk_in = 1'b0;
  logic             reset_n = 1'b0;
  logic [65:0]      data_in = '0;
  logic             data_valid = 1'b0;
  logic [AW-1:0]    rd_address = '0;
  logic [127:0]     rd_data;
  logic             rd_page_done = 1'b0;
  logic [PR_W-1:0]  pages_ready;
  logic             ring_full, overflow, underflow;
  logic [CNT_W-1:0] dropped_pages;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  sonic_rx_page_ring #(
    .NUM_PAGES(NUM_PAGES), .PAGE_WORDS(PAGE_WORDS), .SYNC_WORDS(SYNC_WORDS),
    .BLOCKS_PER_PAGE(BPP), .CNT_W(CNT_W)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .rd_page_done (rd_page_done),
    .pages_ready  (pages_ready),
    .ring_full    (ring_full),
    .overflow     (overflow),
    .underflow    (underflow),
    .dropped_pages(dropped_pages)
  );

  // Reference model state.
  logic [127:0] m_mem [NUM_PAGES*PAGE_WORDS];
  bit           m_valid [NUM_PAGES];
  int           m_ready, m_wpage, m_k, m_dropped;
  bit           m_fill, m_over, m_under;
  logic [63:0]  first_pay [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    m_ready = 0; m_wpage = 0; m_k = 0; m_dropped = 0;
    m_fill = 0; m_over = 0; m_under = 0;
  endtask

  task automatic model_release();
    if (m_ready == 0) m_under = 1;
    else m_ready--;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ready"}, 128'(pages_ready), 128'(m_ready));
    check({tag, "_full"},  128'(ring_full),   128'(m_ready == NUM_PAGES));
    check({tag, "_ovf"},   128'(overflow),    128'(m_over));
    check({tag, "_unf"},   128'(underflow),   128'(m_under));
    check({tag, "_drop"},  128'(dropped_pages), 128'(m_dropped));
  endtask

  task automatic idle(input bit rel);
    data_valid   = 1'b0;
    rd_page_done = rel;
    if (rel) model_release();
    tick();
    rd_page_done = 1'b0;
  endtask

  // One block; the model applies the page decision at k == 0, then the
  // release, then placement and page completion.
  task automatic send_block(input logic [1:0] h, input logic [63:0] p, input bit rel);
    int base;
    data_in      = {p, h};
    data_valid   = 1'b1;
    rd_page_done = rel;
    if (m_k == 0) begin
      m_fill = (m_ready < NUM_PAGES) || rel;
      if (m_fill)
        for (int w = 0; w < SYNC_WORDS; w++) m_mem[m_wpage*PAGE_WORDS + w] = '0;
    end
    if (rel) model_release();
    if (m_fill) begin
      base = m_wpage * PAGE_WORDS;
      m_mem[base + m_k/64][2*(m_k%64) +: 2] = h;
      m_mem[base + SYNC_WORDS + m_k/2][64*(m_k%2) +: 64] = p;
    end
    if (m_k == BPP-1) begin
      if (m_fill) begin
        m_valid[m_wpage] = 1;
        m_ready++;
        m_wpage = (m_wpage + 1) % NUM_PAGES;
      end else begin
        m_over = 1;
        if (m_dropped < (1 << CNT_W) - 1) m_dropped++;
      end
      m_k = 0;
    end else begin
      m_k++;
    end
    tick();
    data_valid   = 1'b0;
    rd_page_done = 1'b0;
  endtask

  // Sends blocks until the current page ends. Directed pages use header k%4
  // and payload k with no gaps; random pages get random data, idle gaps and
  // releases (never on the last block) with probability 1/rel_div.
  task automatic send_page(input bit directed, input int rel_div);
    do begin
      logic [1:0]  h;
      logic [63:0] p;
      bit          rel, is_last;
      is_last = (m_k == BPP-1);
      if (directed) begin
        h = 2'(m_k % 4);
        p = 64'(m_k);
      end else begin
        h = 2'($urandom);
        p = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) idle(1'b0);
      end
      rel = (rel_div > 0) && !is_last && ($urandom_range(0, rel_div-1) == 0);
      if (m_k < 2) first_pay[m_k] = p;
      send_block(h, p, rel);
    end while (m_k != 0);
  endtask

  task automatic read_word(input int page, input int word, output logic [127:0] d);
    rd_address = AW'(page*PAGE_WORDS + word);
    tick();
    tick();
    d = rd_data;
  endtask

  initial begin
    logic [127:0] d, exp;
    logic [127:0] post_w8;
    int seq_w [3];
    model_reset();

    // Reset state.
    repeat (3) tick();
    check_state("rst");
    check("rst_rd", rd_data, '0);
    reset_n = 1'b1;
    tick();

    // Directed page: header k%4, payload k.
    send_page(1'b1, 0);
    check("t1_ready_t1", 128'(pages_ready), 128'd0);
    tick();
    check_state("t1");
    exp = '0;
    for (int k = 0; k < 64; k++) exp[2*k +: 2] = 2'(k % 4);
    read_word(0, 0, d);   check("t1_w0", d, exp);
    exp = '0;
    for (int k = 448; k < BPP; k++) exp[2*(k-448) +: 2] = 2'(k % 4);
    read_word(0, 7, d);   check("t1_w7", d, exp);
    check("t1_w7_pad", 128'(d[127:96]), 128'd0);
    read_word(0, 8, d);   check("t1_w8", d, {64'd1, 64'd0});
    read_word(0, 255, d); check("t1_w255", d, {64'd495, 64'd494});

    // Commit and release in the same cycle, then drain and underflow.
    send_page(1'b0, 0);
    idle(1'b1);
    check("t2_same_cyc", 128'(pages_ready), 128'(m_ready));
    tick();
    check("t2_same_cyc2", 128'(pages_ready), 128'd1);
    idle(1'b1);
    check_state("t2_drain");
    idle(1'b1);
    check_state("t2_unf");

    // Reset in the middle of a page.
    send_page(1'b0, 0);
    tick();
    check_state("t3_pre");
    for (int k = 0; k < 200; k++) send_block(2'($urandom), {$urandom, $urandom}, 1'b0);
    reset_n    = 1'b0;
    data_valid = 1'b1;
    data_in    = {$urandom, $urandom, 2'($urandom)};
    tick();
    tick();
    data_valid = 1'b0;
    model_reset();
    check_state("t3_rst");
    check("t3_rst_rd", rd_data, '0);
    reset_n = 1'b1;
    send_page(1'b0, 0);
    post_w8 = {first_pay[1], first_pay[0]};
    tick();
    tick();
    check_state("t3_post");
    read_word(0, 8, d); check("t3_w8", d, post_w8);

    // Fill the ring, then one page more is dropped.
    for (int i = 0; i < NUM_PAGES-1; i++) send_page(1'b0, 0);
    check("t4_ready_t1", 128'(pages_ready), 128'(NUM_PAGES-1));
    check("t4_full_t1", 128'(ring_full), 128'd0);
    tick();
    check_state("t4_full");
    send_page(1'b0, 0);
    check("t4_ovf_t1", 128'(overflow), 128'd0);
    tick();
    check_state("t4_drop");
    read_word(0, 8, d);   check("t4_p0_w8", d, post_w8);
    read_word(0, 0, d);   check("t4_p0_w0", d, m_mem[0]);
    read_word(0, 255, d); check("t4_p0_w255", d, m_mem[255]);

    // Ring full, release arrives with block 0: page accepted.
    send_block(2'($urandom), {$urandom, $urandom}, 1'b1);
    check("t5_ready_k0", 128'(pages_ready), 128'(NUM_PAGES-1));
    send_page(1'b0, 0);
    tick();
    check_state("t5");

    // Back-to-back reads of words 7, 8, 7 across both RAMs.
    seq_w = '{7, 8, 7};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) rd_address = AW'(seq_w[i]);
      tick();
      if (i >= 1) check($sformatf("t6_b2b%0d", i-1), rd_data, m_mem[seq_w[i-1]]);
    end

    // Random pages with random releases, then random reads.
    for (int pg = 0; pg < 6; pg++) begin
      send_page(1'b0, 64);
      tick();
      tick();
      check_state($sformatf("t7_pg%0d", pg));
    end
    for (int i = 0; i < 12; i++) begin
      int p, w;
      p = $urandom_range(0, NUM_PAGES-1);
      w = $urandom_range(0, PAGE_WORDS-1);
      if (m_valid[p]) begin
        read_word(p, w, d);
        check($sformatf("t7_rd_p%0d_w%0d", p, w), d, m_mem[p*PAGE_WORDS + w]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
